seg7_scan_decoder: RTL and testbench
====================================

# seg7_scan_decoder

Receive-side counterpart to the team's BCD-to-7-segment encoder. It samples a time-multiplexed 4-digit common-cathode display bus (7 segment lines plus one-hot digit enables) driven by an external scanner and reconstructs the displayed BCD digits. A digit is captured only after its pattern has been stable for a qualifying dwell. Captured digits are assembled into frames and delivered over a valid/ready handshake to a consumer such as a bus register or a checker.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical synchronized samples required before a digit is captured; legal range 1..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `seg` in 7: segment lines, bit0=a … bit6=g, active-high; asynchronous to `clk`.
- `dig_en` in 4: digit enables, active-high, expected one-hot; bit0 is the rightmost digit; asynchronous to `clk`.
- `frame_digits` out 16: digit codes; bits [4i+3:4i] hold digit i.
- `frame_err` out 4: per-digit flag; pattern was not a legal code.
- `frame_blank` out 4: per-digit flag; pattern was 7'h00.
- `frame_valid` out 1: frame is held and available.
- `frame_ready` in 1: consumer accepts the frame.
- `overrun` out 1: sticky; a frame was dropped.
- `ovr_clr` in 1: synchronous clear of `overrun`.

## Operation
- **Synchronizer.** `seg` and `dig_en` each pass through 2-flop synchronizers. The synchronized values are `s_seg` and `s_en`.
- **Dwell FSM.** States are IDLE, COUNT and HELD.
  - IDLE → COUNT when `s_en` is one-hot. Entering COUNT latches `{s_seg,s_en}` into `last` and sets `cnt=1`.
  - COUNT: if `{s_seg,s_en}==last`, then `cnt++`. When `cnt` reaches `STABLE_CYCLES`, capture and go to HELD. Any change reloads `last` and sets `cnt=1`. A non-one-hot `s_en` sends the FSM to IDLE.
  - HELD: no recapture. Any change returns the FSM to COUNT (if the new `s_en` is one-hot) or to IDLE (otherwise).
- **Counter width.** `cnt` is `$clog2(STABLE_CYCLES+1)` bits wide and saturates.
- **Decode table.** 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - 7'h00 → code 4'h0, blank=1, err=0.
  - Any other pattern → code 4'h0, err=1.
- **Capture.** The decoded result is written into slot i, where i is the set bit of `s_en`, and `got[i]` is set.
- **Frame assembly.** When `got==4'hF`, the four slots, err flags and blank flags load into the output register and `got` clears.
  - If `frame_valid` is already high and `frame_ready` is low at that edge, the frame is dropped and `overrun` is set.
  - If `frame_valid && frame_ready`, the old frame retires and the new frame loads on the same edge, with no overrun.
- **Slot overwrite.** A slot captured twice before a frame completes is overwritten; the latest capture wins.
- **Overrun flag.** `ovr_clr` clears `overrun` unless an overrun occurs on the same edge; in that case `overrun` stays 1.

## Timing
- **Reset values.** All outputs are 0. Reset also sets the FSM to IDLE, `cnt=0`, `got=0`, `last=0`, and clears the synchronizers.
- **Reset mid-dwell or mid-frame.** Partial captures are discarded. After reset release, the FSM restarts from IDLE.
- **Capture latency.** Let N be the first edge at which a new stable input is sampled by the first synchronizer flop.
  - `s_*` changes after edge N+1.
  - COUNT begins at N+2 with `cnt=1`.
  - Capture happens at edge N+1+`STABLE_CYCLES`.
- **Frame latency.** `frame_valid` rises at the edge after the fourth capture.
- **Handshake.** A transfer occurs at an edge with `frame_valid && frame_ready`. `frame_valid` falls at that edge unless a new frame loads. Outputs are stable while valid is high and ready is low.
- **Short dwells.** A dwell shorter than `STABLE_CYCLES` synchronized samples produces no capture.

## Configuration
- `SEG7_HEX_EN` defined: the decode table additionally maps A=77, b=7C, C=39, d=5E, E=79, F=71 to codes A–F with err=0.
- `SEG7_HEX_EN` undefined: those six patterns set err=1 and code 0.

## Structure
- **Package `seg7_pkg`:**
  - segment pattern localparams for 0–9 and A–F;
  - the blank pattern;
  - the dwell state enum;
  - the `decode_seg` function returning `{err, blank, code[3:0]}`.
- **Sub-module `seg7_dwell_fsm`:** synchronized inputs in; capture strobe, slot index and pattern out. The top level holds the slots, frame register and handshake.

## Test plan
- **Basic frame.** Scan digits 3,1,4,1 (4F,06,66,06) with a dwell of 8 cycles each and `frame_ready=1` → `frame_digits=16'h1413`, err=0, blank=0; `frame_valid` pulses for 1 cycle.
- **Short dwell.** Dwell of 2 cycles with `STABLE_CYCLES=4` → no capture and no `frame_valid`. Then extend digit 0 to 6 cycles → `got[0]` set.
- **Illegal and blank patterns.**
  - Digit 2 pattern 7'h77 without `SEG7_HEX_EN` → `frame_err=4'b0100`, code 0.
  - With `SEG7_HEX_EN` → code A, err=0.
  - Digit 1 pattern 7'h00 → `frame_blank=4'b0010`.
- **Overrun.** Hold `frame_ready=0` across two complete frames → the first frame is retained and `overrun=1`. `ovr_clr` pulse → `overrun=0`. Ready and a new frame on the same edge → new frame loads with no overrun.
- **Enable faults.** `dig_en=4'b0011` for 10 cycles → FSM in IDLE, no capture. `dig_en=4'b0000` → IDLE.
- **Reset mid-operation.** Assert `rst_n` low after 3 of 4 digits are captured → all outputs 0. The next full scan yields only the new digits.

Source files
------------

// File: rtl/seg7_scan_decoder_pkg.sv
// Segment patterns, dwell states and the pattern-to-BCD decoder for the scan decoder.
// SEG7_HEX_EN: when defined, patterns A-F decode to codes A-F instead of flagging an error.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HELD  = 2'd2
  } dwell_state_e;

  // Returns {err, blank, code[3:0]}; unknown patterns report code 0 with err set.
  function automatic logic [5:0] decode_seg(input logic [6:0] pat);
    logic       err;
    logic       blank;
    logic [3:0] code;
    err   = 1'b0;
    blank = 1'b0;
    code  = 4'h0;
    case (pat)
      SEG_0:     code = 4'h0;
      SEG_1:     code = 4'h1;
      SEG_2:     code = 4'h2;
      SEG_3:     code = 4'h3;
      SEG_4:     code = 4'h4;
      SEG_5:     code = 4'h5;
      SEG_6:     code = 4'h6;
      SEG_7:     code = 4'h7;
      SEG_8:     code = 4'h8;
      SEG_9:     code = 4'h9;
      SEG_BLANK: blank = 1'b1;
`ifdef SEG7_HEX_EN
      SEG_A:     code = 4'hA;
      SEG_B:     code = 4'hB;
      SEG_C:     code = 4'hC;
      SEG_D:     code = 4'hD;
      SEG_E:     code = 4'hE;
      SEG_F:     code = 4'hF;
`endif
      default:   err = 1'b1;
    endcase
    return {err, blank, code};
  endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Frame delivery channel: decoded digits plus per-digit flags under valid/ready.
// Master holds the frame stable while valid is high and ready is low.
interface seg7_scan_decoder_if;
  logic [15:0] frame_digits;
  logic [3:0]  frame_err;
  logic [3:0]  frame_blank;
  logic        frame_valid;
  logic        frame_ready;

  modport master (
    output frame_digits, frame_err, frame_blank, frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame_digits, frame_err, frame_blank, frame_valid,
    output frame_ready
  );
endinterface

// File: rtl/seg7_scan_decoder_dwell_fsm.sv
// Qualifies a synchronized digit pattern after STABLE_CYCLES identical samples; one capture
// strobe per stable dwell, combinational from registered state. No backpressure.
module seg7_dwell_fsm
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] s_seg,
  input  logic [3:0] s_en,
  output logic       cap_vld,
  output logic [1:0] cap_idx,
  output logic [6:0] cap_seg
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  dwell_state_e  state_q, state_d;
  logic [10:0]   last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [10:0]   cur;
  logic          one_hot;
  logic          match;

  assign cur     = {s_seg, s_en};
  assign one_hot = (s_en != 4'h0) && ((s_en & (s_en - 4'h1)) == 4'h0);
  assign match   = (cur == last_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    cap_vld = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (one_hot) begin
          state_d = ST_COUNT;
          last_d  = cur;
          cnt_d   = CW'(1);
        end
      end
      ST_COUNT: begin
        if (!one_hot) begin
          state_d = ST_IDLE;
        end else if (match) begin
          if (cnt_q != CW'(STABLE_CYCLES)) cnt_d = cnt_q + CW'(1);
        end else begin
          last_d = cur;
          cnt_d  = CW'(1);
        end
      end
      ST_HELD: begin
        if (!match) begin
          if (one_hot) begin
            state_d = ST_COUNT;
            last_d  = cur;
            cnt_d   = CW'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Reaching the threshold captures on this same edge, so STABLE_CYCLES=1 captures on entry.
    if (state_d == ST_COUNT && cnt_d == CW'(STABLE_CYCLES)) begin
      cap_vld = 1'b1;
      state_d = ST_HELD;
    end
  end

  always_comb begin
    cap_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (s_en[i]) cap_idx = 2'(i);
    end
  end

  assign cap_seg = s_seg;

endmodule

// File: rtl/seg7_scan_decoder.sv
// Rebuilds 4-digit BCD frames from a scanned 7-seg bus (SEG7_HEX_EN adds A-F); capture at
// N+1+STABLE_CYCLES, frame one edge later. Ready low holds the frame; a new one is dropped (overrun).
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [6:0]                  seg,
  input  logic [3:0]                  dig_en,
  seg7_scan_decoder_if.master         frm,
  output logic                        overrun,
  input  logic                        ovr_clr
);

  logic [6:0]  seg_meta_q, seg_meta_d, s_seg_q, s_seg_d;
  logic [3:0]  en_meta_q, en_meta_d, s_en_q, s_en_d;
  logic [15:0] slot_code_q, slot_code_d;
  logic [3:0]  slot_err_q, slot_err_d;
  logic [3:0]  slot_blank_q, slot_blank_d;
  logic [3:0]  got_q, got_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  err_q, err_d;
  logic [3:0]  blank_q, blank_d;
  logic        valid_q, valid_d;
  logic        ovr_q, ovr_d;

  logic        cap_vld;
  logic [1:0]  cap_idx;
  logic [6:0]  cap_seg;
  logic [5:0]  dec;
  logic        frame_done;
  logic        drop;

  seg7_dwell_fsm #(.STABLE_CYCLES(STABLE_CYCLES)) u_dwell (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_seg   (s_seg_q),
    .s_en    (s_en_q),
    .cap_vld (cap_vld),
    .cap_idx (cap_idx),
    .cap_seg (cap_seg)
  );

  assign dec        = decode_seg(cap_seg);
  assign frame_done = (got_q == 4'hF);
  assign drop       = frame_done && valid_q && !frm.frame_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_meta_q   <= '0;
      s_seg_q      <= '0;
      en_meta_q    <= '0;
      s_en_q       <= '0;
      slot_code_q  <= '0;
      slot_err_q   <= '0;
      slot_blank_q <= '0;
      got_q        <= '0;
      digits_q     <= '0;
      err_q        <= '0;
      blank_q      <= '0;
      valid_q      <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      seg_meta_q   <= seg_meta_d;
      s_seg_q      <= s_seg_d;
      en_meta_q    <= en_meta_d;
      s_en_q       <= s_en_d;
      slot_code_q  <= slot_code_d;
      slot_err_q   <= slot_err_d;
      slot_blank_q <= slot_blank_d;
      got_q        <= got_d;
      digits_q     <= digits_d;
      err_q        <= err_d;
      blank_q      <= blank_d;
      valid_q      <= valid_d;
      ovr_q        <= ovr_d;
    end
  end

  always_comb begin
    seg_meta_d   = seg;
    s_seg_d      = seg_meta_q;
    en_meta_d    = dig_en;
    s_en_d       = en_meta_q;
    slot_code_d  = slot_code_q;
    slot_err_d   = slot_err_q;
    slot_blank_d = slot_blank_q;
    got_d        = got_q;
    digits_d     = digits_q;
    err_d        = err_q;
    blank_d      = blank_q;
    valid_d      = valid_q;

    if (valid_q && frm.frame_ready) valid_d = 1'b0;

    // A completed frame always empties the slots, whether it loads or is dropped.
    if (frame_done) begin
      got_d = 4'h0;
      if (!drop) begin
        digits_d = slot_code_q;
        err_d    = slot_err_q;
        blank_d  = slot_blank_q;
        valid_d  = 1'b1;
      end
    end

    if (cap_vld) begin
      slot_code_d[{cap_idx, 2'b00} +: 4] = dec[3:0];
      slot_blank_d[cap_idx]              = dec[4];
      slot_err_d[cap_idx]                = dec[5];
      got_d[cap_idx]                     = 1'b1;
    end

    ovr_d = (ovr_q && !ovr_clr) || drop;
  end

  assign frm.frame_digits = digits_q;
  assign frm.frame_err    = err_q;
  assign frm.frame_blank  = blank_q;
  assign frm.frame_valid  = valid_q;
  assign overrun          = ovr_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: expected frames are queued as digits are scanned and
// compared when the DUT hands a frame over.
module tb_seg7_scan_decoder;
  import seg7_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] seg = '0;
  logic [3:0] dig_en = '0;
  logic       overrun;
  logic       ovr_clr = 1'b0;

  int checks = 0;
  int failures = 0;
  int valid_cycles = 0;
  int vbase;
  logic [23:0] exp_q[$];

  seg7_scan_decoder_if frm();

  seg7_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .seg     (seg),
    .dig_en  (dig_en),
    .frm     (frm),
    .overrun (overrun),
    .ovr_clr (ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] s, input logic [3:0] e, input int cyc);
    seg    = s;
    dig_en = e;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic scan4(input logic [6:0] p0, input logic [6:0] p1,
                       input logic [6:0] p2, input logic [6:0] p3);
    drive(p0, 4'b0001, 8);
    drive(p1, 4'b0010, 8);
    drive(p2, 4'b0100, 8);
    drive(p3, 4'b1000, 8);
    drive(7'h00, 4'b0000, 8);
  endtask

  // Scoreboard side: a frame is consumed at the edge following a negedge with valid and ready.
  always @(negedge clk) begin
    if (rst_n && frm.frame_valid) begin
      valid_cycles++;
      if (frm.frame_ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          failures++;
          $error("FAIL unexpected_frame observed=%0h expected=none", frm.frame_digits);
        end
        if (exp_q.size() != 0) begin
          logic [23:0] e;
          e = exp_q.pop_front();
          check("frame_digits", frm.frame_digits, e[23:8]);
          check("frame_err", frm.frame_err, e[7:4]);
          check("frame_blank", frm.frame_blank, e[3:0]);
        end
      end
    end
  end

  initial begin
    frm.frame_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", frm.frame_valid, 0);
    check("rst_digits", frm.frame_digits, 0);
    check("rst_err", frm.frame_err, 0);
    check("rst_blank", frm.frame_blank, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    drive(7'h00, 4'b0000, 3);

    // Basic frame 3,1,4,1 with ready high: one-cycle valid pulse.
    frm.frame_ready = 1'b1;
    vbase = valid_cycles;
    exp_q.push_back({16'h1413, 4'h0, 4'h0});
    scan4(SEG_3, SEG_1, SEG_4, SEG_1);
    check("basic_valid_pulse", valid_cycles - vbase, 1);
    check("basic_valid_low", frm.frame_valid, 0);

    // Short dwell on digit 0 must not capture; the rest alone cannot complete a frame.
    vbase = valid_cycles;
    drive(SEG_8, 4'b0001, 2);
    drive(7'h00, 4'b0000, 4);
    drive(SEG_2, 4'b0010, 8);
    drive(SEG_3, 4'b0100, 8);
    drive(SEG_0, 4'b1000, 8);
    drive(7'h00, 4'b0000, 8);
    check("short_dwell_no_frame", valid_cycles - vbase, 0);
    exp_q.push_back({16'h0325, 4'h0, 4'h0});
    drive(SEG_5, 4'b0001, 6);
    drive(7'h00, 4'b0000, 8);
    check("long_dwell_frame", valid_cycles - vbase, 1);

    // Illegal and blank patterns.
`ifdef SEG7_HEX_EN
    exp_q.push_back({16'h7A00, 4'b0000, 4'b0010});
`else
    exp_q.push_back({16'h7000, 4'b0100, 4'b0010});
`endif
    scan4(SEG_0, SEG_BLANK, SEG_A, SEG_7);

    // Overrun: ready low across two frames keeps the first one.
    frm.frame_ready = 1'b0;
    exp_q.push_back({16'h4321, 4'h0, 4'h0});
    scan4(SEG_1, SEG_2, SEG_3, SEG_4);
    check("held_valid", frm.frame_valid, 1);
    check("held_overrun_clear", overrun, 0);
    scan4(SEG_5, SEG_6, SEG_7, SEG_8);
    check("ovr_set", overrun, 1);
    check("ovr_valid_held", frm.frame_valid, 1);
    check("ovr_digits_held", frm.frame_digits, 16'h4321);
    ovr_clr = 1'b1;
    drive(7'h00, 4'b0000, 1);
    ovr_clr = 1'b0;
    check("ovr_cleared", overrun, 0);

    // Ready rises exactly on the edge the next frame loads: old retires, new loads, no overrun.
    exp_q.push_back({16'h2109, 4'h0, 4'h0});
    drive(SEG_9, 4'b0001, 8);
    drive(SEG_0, 4'b0010, 8);
    drive(SEG_1, 4'b0100, 8);
    drive(SEG_2, 4'b1000, 6);
    frm.frame_ready = 1'b1;
    drive(SEG_2, 4'b1000, 3);
    drive(7'h00, 4'b0000, 6);
    check("same_edge_no_ovr", overrun, 0);
    check("same_edge_drained", frm.frame_valid, 0);

    // Hold a flagged frame, then fault the enables: no capture may reach slot 0.
    frm.frame_ready = 1'b0;
    scan4(SEG_0, SEG_BLANK, SEG_A, SEG_1);
    check("fault_pre_valid", frm.frame_valid, 1);
    drive(SEG_0, 4'b0011, 10);
    drive(SEG_0, 4'b0000, 4);
    drive(SEG_1, 4'b0010, 8);
    drive(SEG_2, 4'b0100, 8);
    drive(SEG_3, 4'b1000, 8);
    drive(7'h00, 4'b0000, 8);
    check("fault_no_overrun", overrun, 0);
`ifdef SEG7_HEX_EN
    check("fault_digits_held", frm.frame_digits, 16'h1A00);
`else
    check("fault_digits_held", frm.frame_digits, 16'h1000);
`endif

    // Reset mid-dwell with three slots filled and a frame held.
    drive(SEG_4, 4'b0001, 3);
    rst_n = 1'b0;
    drive(7'h00, 4'b0000, 2);
    check("mid_rst_valid", frm.frame_valid, 0);
    check("mid_rst_digits", frm.frame_digits, 0);
    check("mid_rst_err", frm.frame_err, 0);
    check("mid_rst_blank", frm.frame_blank, 0);
    check("mid_rst_overrun", overrun, 0);
    frm.frame_ready = 1'b1;
    rst_n = 1'b1;
    drive(7'h00, 4'b0000, 3);
    vbase = valid_cycles;
    drive(SEG_2, 4'b0001, 8);
    drive(7'h00, 4'b0000, 8);
    check("post_rst_partial", valid_cycles - vbase, 0);
    exp_q.push_back({16'h6789, 4'h0, 4'h0});
    scan4(SEG_9, SEG_8, SEG_7, SEG_6);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
